mem_arbiter: RTL and testbench

- Shares the single combinational d_mem port between two requesters: port 1 (instruction fetch) and port 2 (load/store unit).
- Accepts at most one request per cycle with a valid/ready handshake and drives d_mem during that cycle.
- Registers read data and returns it one cycle later.
- Port 2 has priority; a bounded starvation counter guarantees port 1 progress.
- Sits between the core's fetch/LSU and d_mem, replacing direct wiring of one port to memory.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and request layout for the two-port d_mem arbiter.
package mem_arbiter_pkg;
    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef struct packed {
        logic                wr;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
    } mem_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority selector: load/store wins, fetch forced through once starved.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic [1:0] valid,
    input  logic [3:0] starve_cnt,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (valid[PORT_IF] && valid[PORT_LS]) begin
            if (starve_cnt == 4'(STARVE_MAX))
                grant[PORT_IF] = 1'b1;
            else
                grant[PORT_LS] = 1'b1;
        end else if (valid[PORT_IF]) begin
            grant[PORT_IF] = 1'b1;
        end else if (valid[PORT_LS]) begin
            grant[PORT_LS] = 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational d_mem port between fetch (port 1) and LSU (port 2);
// read data is registered and returned one cycle after the handshake.
module mem_arbiter #(
    parameter int ADDR_W     = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = mem_arbiter_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io1_req_valid,
    output logic                io1_req_ready,
    input  logic                io1_wr,
    input  logic [ADDR_W-1:0]   io1_addr,
    input  logic [DATA_W-1:0]   io1_wdata,
    input  logic [DATA_W/8-1:0] io1_wstrb,
    output logic                io1_resp_valid,
    output logic [DATA_W-1:0]   io1_rdata,
    input  logic                io2_req_valid,
    output logic                io2_req_ready,
    input  logic                io2_wr,
    input  logic [ADDR_W-1:0]   io2_addr,
    input  logic [DATA_W-1:0]   io2_wdata,
    input  logic [DATA_W/8-1:0] io2_wstrb,
    output logic                io2_resp_valid,
    output logic [DATA_W-1:0]   io2_rdata,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);
    import mem_arbiter_pkg::*;

    // Same layout as mem_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic                wr;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
    } req_t;

    logic [1:0] valid, grant, hs;
    logic [3:0] starve_cnt;
    req_t       req1, req2, sel;

    assign valid = {io2_req_valid, io1_req_valid};
    assign req1  = {io1_wr, io1_addr, io1_wdata, io1_wstrb};
    assign req2  = {io2_wr, io2_addr, io2_wdata, io2_wstrb};

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .valid      (valid),
        .starve_cnt (starve_cnt),
        .grant      (grant)
    );

    // Grant only ever names a valid port, so a gated grant is the handshake itself.
    assign hs            = reset ? 2'b00 : grant;
    assign io1_req_ready = hs[PORT_IF];
    assign io2_req_ready = hs[PORT_LS];

    always_comb begin
        sel = '0;
        if (hs[PORT_LS])
            sel = req2;
        else if (hs[PORT_IF])
            sel = req1;
    end

    assign mem_en    = |hs;
    assign mem_wr    = sel.wr;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;
    assign mem_wstrb = sel.wstrb;

    always_ff @(posedge clock) begin
        if (reset) begin
            io1_resp_valid <= 1'b0;
            io2_resp_valid <= 1'b0;
            io1_rdata      <= '0;
            io2_rdata      <= '0;
            starve_cnt     <= '0;
        end else begin
            io1_resp_valid <= hs[PORT_IF];
            io2_resp_valid <= hs[PORT_LS];
            if (hs[PORT_IF])
                io1_rdata <= sel.wr ? '0 : mem_rdata;
            if (hs[PORT_LS])
                io2_rdata <= sel.wr ? '0 : mem_rdata;
            if (hs[PORT_IF])
                starve_cnt <= '0;
            else if (valid[PORT_IF] && hs[PORT_LS] && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small word-addressed d_mem model.
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        io1_req_valid, io1_req_ready, io1_wr, io1_resp_valid;
    logic [31:0] io1_addr, io1_wdata, io1_rdata;
    logic [3:0]  io1_wstrb;
    logic        io2_req_valid, io2_req_ready, io2_wr, io2_resp_valid;
    logic [31:0] io2_addr, io2_wdata, io2_rdata;
    logic [3:0]  io2_wstrb;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [0:255];

    typedef struct {
        int          port;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    int          model_cnt;
    logic [31:0] exp_r1, exp_r2;
    int          checks, errors;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .io1_req_valid(io1_req_valid), .io1_req_ready(io1_req_ready), .io1_wr(io1_wr),
        .io1_addr(io1_addr), .io1_wdata(io1_wdata), .io1_wstrb(io1_wstrb),
        .io1_resp_valid(io1_resp_valid), .io1_rdata(io1_rdata),
        .io2_req_valid(io2_req_valid), .io2_req_ready(io2_req_ready), .io2_wr(io2_wr),
        .io2_addr(io2_addr), .io2_wdata(io2_wdata), .io2_wstrb(io2_wstrb),
        .io2_resp_valid(io2_resp_valid), .io2_rdata(io2_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // d_mem: combinational read, byte-strobed write at the edge, preloaded during reset.
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}};
            mem[0] <= 32'hDEAD_BEEF;
            mem[4] <= 32'hFFFF_FFFF;
        end else if (mem_en && mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic set1(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        io1_req_valid = v; io1_wr = w; io1_addr = a; io1_wdata = d; io1_wstrb = s;
    endtask

    task automatic set2(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        io2_req_valid = v; io2_wr = w; io2_addr = a; io2_wdata = d; io2_wstrb = s;
    endtask

    // One clock: check request-side outputs against the model, push the expected
    // response, cross the edge, then pop and check the response side.
    task automatic step(output logic [1:0] rdy);
        logic [1:0]  g, exp_v;
        logic        w;
        logic [31:0] a, d;
        logic [3:0]  s;
        resp_t       e;
        #1;
        rdy = {io2_req_ready, io1_req_ready};
        g = 2'b00;
        if (!reset) begin
            if (io1_req_valid && io2_req_valid) g = (model_cnt == 4) ? 2'b01 : 2'b10;
            else if (io1_req_valid) g = 2'b01;
            else if (io2_req_valid) g = 2'b10;
        end
        checks++;
        if (rdy !== g) begin
            errors++; $display("FAIL ready: got %b, expected %b", rdy, g);
        end
        w = g[1] ? io2_wr    : io1_wr;
        a = g[1] ? io2_addr  : io1_addr;
        d = g[1] ? io2_wdata : io1_wdata;
        s = g[1] ? io2_wstrb : io1_wstrb;
        checks++;
        if (g != 2'b00) begin
            if ({mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, w, a, d, s}) begin
                errors++;
                $display("FAIL mem_drive: got en=%b wr=%b a=%h d=%h s=%h, expected wr=%b a=%h d=%h s=%h",
                         mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb, w, a, d, s);
            end
            q.push_back('{port: g[1] ? 2 : 1, data: w ? 32'h0 : mem[a[9:2]]});
        end else if ({mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb} !== 70'h0) begin
            errors++;
            $display("FAIL mem_idle: got en=%b wr=%b a=%h d=%h s=%h, expected all zero",
                     mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb);
        end
        if (reset) model_cnt = 0;
        else if (g == 2'b10 && io1_req_valid) model_cnt = (model_cnt == 4) ? 4 : model_cnt + 1;
        else if (g == 2'b01) model_cnt = 0;
        if (reset) begin
            q.delete(); exp_r1 = '0; exp_r2 = '0;
        end
        @(posedge clock); #1;
        exp_v = 2'b00;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.port == 1) begin exp_v = 2'b01; exp_r1 = e.data; end
            else begin exp_v = 2'b10; exp_r2 = e.data; end
        end
        checks++;
        if ({io2_resp_valid, io1_resp_valid} !== exp_v) begin
            errors++;
            $display("FAIL resp_valid: got %b, expected %b", {io2_resp_valid, io1_resp_valid}, exp_v);
        end
        checks++;
        if (io1_rdata !== exp_r1 || io2_rdata !== exp_r2) begin
            errors++;
            $display("FAIL rdata: got %h/%h, expected %h/%h", io1_rdata, io2_rdata, exp_r1, exp_r2);
        end
        checks++;
        if (dut.starve_cnt !== 4'(model_cnt)) begin
            errors++; $display("FAIL starve_cnt: got %0d, expected %0d", dut.starve_cnt, model_cnt);
        end
    endtask

    task automatic test_reset();
        logic [1:0] r;
        reset = 1'b1;
        set1(1, 0, 32'h8000_0000, 0, 0);
        set2(1, 0, 32'h8000_0010, 0, 0);
        for (int i = 0; i < 3; i++) step(r);
        reset = 1'b0;
        step(r);
        checks++;
        if (r !== 2'b10) begin
            errors++; $display("FAIL first_grant: got %b, expected 10", r);
        end
        set1(0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0);
        step(r);
    endtask

    task automatic test_port1_read();
        logic [1:0] r;
        set1(1, 0, 32'h8000_0000, 0, 0);
        step(r);
        set1(0, 0, 0, 0, 0);
        checks++;
        if (r !== 2'b01 || io1_resp_valid !== 1'b1 || io2_resp_valid !== 1'b0 ||
            io1_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL p1_read: got rdy=%b rv=%b/%b rdata=%h, expected 01 1/0 deadbeef",
                     r, io1_resp_valid, io2_resp_valid, io1_rdata);
        end
        step(r);
    endtask

    task automatic test_write_read();
        logic [1:0] r;
        set2(1, 1, 32'h8000_0010, 32'h1234_5678, 4'h3);
        step(r);
        checks++;
        if (io2_resp_valid !== 1'b1 || io2_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_resp: got rv=%b rdata=%h, expected 1 0", io2_resp_valid, io2_rdata);
        end
        set2(1, 0, 32'h8000_0010, 0, 0);
        step(r);
        set2(0, 0, 0, 0, 0);
        checks++;
        if (io2_resp_valid !== 1'b1 || io2_rdata !== 32'hFFFF_5678) begin
            errors++; $display("FAIL rd_after_wr: got rv=%b rdata=%h, expected 1 ffff5678",
                               io2_resp_valid, io2_rdata);
        end
        step(r);
    endtask

    task automatic test_starvation();
        logic [1:0] r;
        int         seq [10];
        int         exp_seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        set1(1, 0, 32'h8000_0020, 0, 0);
        set2(1, 0, 32'h8000_0030, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(r);
            seq[i] = (r == 2'b10) ? 2 : (r == 2'b01) ? 1 : 0;
        end
        set1(0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL grant_seq[%0d]: got %0d, expected %0d", i, seq[i], exp_seq[i]);
            end
        end
        step(r);
    endtask

    task automatic test_hold();
        logic [1:0] r;
        int         accepted = 0, at = -1, pulses = 0;
        set1(1, 0, 32'h8000_0040, 32'hA5A5_A5A5, 4'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 7) set2(1, 0, 32'h8000_0080 + 32'(4 * i), 0, 0);
            else set2(0, 0, 0, 0, 0);
            step(r);
            if (r[0]) begin accepted++; at = i; set1(0, 0, 0, 0, 0); end
            if (io1_resp_valid) pulses++;
        end
        checks++;
        if (accepted !== 1 || at !== 4 || pulses !== 1) begin
            errors++; $display("FAIL hold: got accepted=%0d at=%0d pulses=%0d, expected 1 4 1",
                               accepted, at, pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        set1(1, 0, 32'h8000_0004, 0, 0);
        set2(1, 0, 32'h8000_0008, 0, 0);
        for (int i = 0; i < 3; i++) step(r);
        reset = 1'b1;
        step(r);
        checks++;
        if (io2_resp_valid !== 1'b0 || io1_resp_valid !== 1'b0 || dut.starve_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_mid: got rv=%b/%b cnt=%0d, expected 0/0 0",
                               io1_resp_valid, io2_resp_valid, dut.starve_cnt);
        end
        reset = 1'b0;
        set1(0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0);
        step(r);
    endtask

    task automatic test_back_to_back();
        logic [1:0] r;
        for (int i = 0; i < 40; i++) begin
            set1($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)), $urandom, 4'($urandom));
            set2($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)), $urandom, 4'($urandom));
            step(r);
        end
        set1(0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0);
        step(r);
    endtask

    initial begin
        checks = 0; errors = 0; model_cnt = 0; exp_r1 = '0; exp_r2 = '0;
        reset = 1'b1;
        set1(0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0);
        test_reset();
        test_port1_read();
        test_write_read();
        test_starvation();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
